// File: rtl/csa_accum_seq_if.sv
// -----------------------------------------------------------------------------
// csa_accum_seq_if
//
// Purpose:
//   Groups the two streaming handshakes of csa_accum_seq: the operand input
//   stream (one beat = LANES operands) and the reduced-sum output stream.
//
// Signals:
//   in_valid   producer has a beat on in_data
//   in_ready   accumulator accepts a beat this cycle
//   in_data    LANES operand lanes, WIDTH bits each
//   out_valid  out_sum holds a resolved result
//   out_ready  consumer accepts out_sum
//   out_sum    resolved sum, WIDTH bits
//
// Modports:
//   master  producer/consumer side (drives in_valid, in_data, out_ready)
//   slave   accumulator side (drives in_ready, out_valid, out_sum)
// -----------------------------------------------------------------------------
interface csa_accum_seq_if #(
   parameter int WIDTH = 16,
   parameter int LANES = 5
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data [LANES];

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_sum
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_sum
   );

endinterface : csa_accum_seq_if

// File: rtl/csa_accum_seq.sv
// -----------------------------------------------------------------------------
// csa_accum_seq
//
// Purpose:
//   Multi-beat accumulation sequencer. One carry-save reduction stage with
//   LANES+2 inputs is time-shared across an arbitrary number of beats: every
//   accepted beat folds its LANES operands together with the registered
//   sum/carry vectors back into a new sum/carry pair. After the last beat a
//   single carry-propagate add resolves the pair and the result is offered on
//   a valid/ready output. All arithmetic is modulo 2^WIDTH.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       job start request, sampled only in IDLE
//   num_beats   beat count of the job, sampled with start (0 = empty job)
//   abort       synchronous cancel, effective in every state except IDLE
//   bus         stream interface (slave side): in_valid/in_ready/in_data,
//               out_valid/out_ready/out_sum
//   busy        high in every state except IDLE
//   beats_left  beats still expected in the current job
// -----------------------------------------------------------------------------
module csa_accum_seq #(
   parameter int WIDTH = 16,
   parameter int LANES = 5,   // LANES+2 must not exceed 7
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_beats,
   input  logic             abort,
   csa_accum_seq_if.slave   bus,
   output logic             busy,
   output logic [CNT_W-1:0] beats_left
);

   localparam int N_IN = LANES + 2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCUM   = 2'd1,
      S_RESOLVE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t           state_q,      state_d;
   logic [WIDTH-1:0] sum_q,        sum_d;
   logic [WIDTH-1:0] carry_q,      carry_d;
   logic [CNT_W-1:0] beats_left_q, beats_left_d;
   logic [WIDTH-1:0] out_sum_q,    out_sum_d;

   // ---------------------------------------------------------------------------
   // Carry-save reduction: LANES operands + registered sum + registered carry
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] csa_in [N_IN];
   logic [WIDTH-1:0] csa_sum;
   logic [WIDTH-1:0] csa_carry;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         csa_in[i] = bus.in_data[i];
      end
      csa_in[LANES]   = sum_q;
      csa_in[LANES+1] = carry_q;
   end

   // Chain of 3:2 compressors: each step absorbs one more vector into the
   // running sum/carry pair, so N_IN vectors need N_IN-2 steps. The carry
   // vector is shifted left inside every step; bits shifted past WIDTH-1 are
   // lost, which is exactly the mod 2^WIDTH behaviour of the final result.
   always_comb begin : csa_tree
      logic [WIDTH-1:0] s_acc;
      logic [WIDTH-1:0] c_acc;
      logic [WIDTH-1:0] x_in;
      logic [WIDTH-1:0] maj;
      // NOTE: blocking assignments are correct here: each compressor step must
      // see the result of the previous one within the same evaluation.
      s_acc = csa_in[0];
      c_acc = csa_in[1];
      for (int i = 2; i < N_IN; i++) begin
         x_in  = csa_in[i];
         maj   = (s_acc & c_acc) | (s_acc & x_in) | (c_acc & x_in);
         s_acc = s_acc ^ c_acc ^ x_in;
         c_acc = maj << 1;
      end
      csa_sum   = s_acc;
      csa_carry = c_acc;
   end

   // ---------------------------------------------------------------------------
   // Next-state / datapath control
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets its hold value first, so no path
      // through the case statement can leave one unassigned (no latches).
      state_d      = state_q;
      sum_d        = sum_q;
      carry_d      = carry_q;
      beats_left_d = beats_left_q;
      out_sum_d    = out_sum_q;

      unique case (state_q)
         S_IDLE: begin
            // abort is meaningless here; start always wins.
            if (start) begin
               if (num_beats != '0) begin
                  sum_d        = '0;
                  carry_d      = '0;
                  beats_left_d = num_beats;
                  state_d      = S_ACCUM;
               end else begin
                  out_sum_d = '0;
                  state_d   = S_DONE;
               end
            end
         end

         S_ACCUM: begin
            // abort beats a same-cycle beat: the beat is simply discarded.
            if (abort) begin
               sum_d        = '0;
               carry_d      = '0;
               beats_left_d = '0;
               state_d      = S_IDLE;
            end else if (bus.in_valid) begin
               sum_d        = csa_sum;
               carry_d      = csa_carry;
               beats_left_d = beats_left_q - 1'b1;
               // Counting down to zero never wraps, even for the largest job.
               if (beats_left_q == CNT_W'(1)) begin
                  state_d = S_RESOLVE;
               end
            end
         end

         S_RESOLVE: begin
            if (abort) begin
               sum_d        = '0;
               carry_d      = '0;
               beats_left_d = '0;
               state_d      = S_IDLE;
            end else begin
               out_sum_d = sum_q + carry_q;
               state_d   = S_DONE;
            end
         end

         S_DONE: begin
            // abort drops the result even if the consumer is ready this cycle.
            if (abort) begin
               sum_d        = '0;
               carry_d      = '0;
               beats_left_d = '0;
               state_d      = S_IDLE;
            end else if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers (synchronous reset)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         sum_q        <= '0;
         carry_q      <= '0;
         beats_left_q <= '0;
         out_sum_q    <= '0;
      end else begin
         state_q      <= state_d;
         sum_q        <= sum_d;
         carry_q      <= carry_d;
         beats_left_q <= beats_left_d;
         out_sum_q    <= out_sum_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: all decoded from registered state only
   // ---------------------------------------------------------------------------
   assign bus.in_ready  = (state_q == S_ACCUM);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.out_sum   = out_sum_q;
   assign busy          = (state_q != S_IDLE);
   assign beats_left    = beats_left_q;

endmodule : csa_accum_seq

// File: tb/tb_csa_accum_seq.sv
// -----------------------------------------------------------------------------
// tb_csa_accum_seq
//
// Self-checking bench for csa_accum_seq. The reference model is plain
// arithmetic: the expected result of a job is the sum of every operand of
// every beat, modulo 2^WIDTH. Expected results are queued when the last beat
// is issued; a monitor pops and compares whenever an output handshake occurs.
// -----------------------------------------------------------------------------
module tb_csa_accum_seq;

   localparam int WIDTH = 16;
   localparam int LANES = 5;
   localparam int CNT_W = 8;

   typedef logic [WIDTH-1:0] lanes_t [LANES];

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] num_beats;
   logic             abort;
   logic             busy;
   logic [CNT_W-1:0] beats_left;

   csa_accum_seq_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

   csa_accum_seq #(
      .WIDTH (WIDTH),
      .LANES (LANES),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_beats  (num_beats),
      .abort      (abort),
      .bus        (bus),
      .busy       (busy),
      .beats_left (beats_left)
   );

   always #5 clk = ~clk;

   int               n_tests = 0;
   int               n_fail  = 0;
   int               hs_count = 0;
   logic [WIDTH-1:0] sb_q [$];
   lanes_t           pat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: counts input handshakes and scores every output handshake.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && abort === 1'b0) begin
         if (bus.in_valid && bus.in_ready) hs_count++;
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) check("unexpected_output", 32'd1, 32'd0);
            else                  check("out_sum", 32'(bus.out_sum), 32'(sb_q.pop_front()));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      start     = 1'b1;
      num_beats = n[CNT_W-1:0];
      step();
      start     = 1'b0;
      num_beats = CNT_W'($urandom);
   endtask

   // Present one beat and hold it until the accepting edge has passed.
   task automatic send_beat(input lanes_t beat);
      int cnt;
      cnt          = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = beat;
      while (!bus.in_ready && cnt < 50) begin
         step();
         cnt++;
      end
      if (cnt >= 50) check("in_ready_timeout", 32'd0, 32'd1);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input bit rnd_ready);
      int cnt;
      cnt = 0;
      while (bus.out_valid && cnt < 100) begin
         bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         step();
         cnt++;
      end
      if (cnt >= 100) check("out_valid_timeout", 32'd0, 32'd1);
      bus.out_ready = 1'b1;
      check("idle_after_out", 32'(busy), 32'd0);
   endtask

   // Full job. rnd_data: random lanes per beat, else 'pat'. gap<0: random gaps.
   // hold_bp: keep out_ready low for 5 cycles in DONE and pulse start meanwhile.
   task automatic run_job(input int n, input bit rnd_data, input int gap,
                          input bit rnd_ready, input bit hold_bp);
      logic [WIDTH-1:0] exp_sum;
      lanes_t           beat;
      int               g;
      exp_sum       = '0;
      bus.out_ready = !(rnd_ready || hold_bp);
      do_start(n);
      check("start_busy", 32'(busy), 32'd1);
      check("start_beats_left", 32'(beats_left), 32'(n));
      for (int b = 0; b < n; b++) begin
         for (int l = 0; l < LANES; l++) begin
            beat[l] = rnd_data ? WIDTH'($urandom) : pat[l];
            exp_sum = exp_sum + beat[l];
         end
         g = (gap < 0) ? $urandom_range(0, 2) : gap;
         repeat (g) step();
         if (b == n - 1) sb_q.push_back(exp_sum);
         send_beat(beat);
         check("beats_left", 32'(beats_left), 32'(n - b - 1));
      end
      // Cycle after final handshake: RESOLVE. Next cycle: DONE.
      check("lat_resolve_no_valid", 32'(bus.out_valid), 32'd0);
      check("lat_resolve_no_ready", 32'(bus.in_ready), 32'd0);
      step();
      check("lat_done_valid", 32'(bus.out_valid), 32'd1);
      if (hold_bp) begin
         for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
               start     = 1'b1;
               num_beats = CNT_W'(7);
            end
            step();
            start = 1'b0;
            check("bp_valid_stable", 32'(bus.out_valid), 32'd1);
            check("bp_sum_stable", 32'(bus.out_sum), 32'(exp_sum));
            check("bp_start_ignored", 32'(beats_left), 32'd0);
         end
      end
      wait_done(rnd_ready);
   endtask

   initial begin
      int hs_before;
      rst_n         = 1'b0;
      start         = 1'b0;
      num_beats     = '0;
      abort         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int l = 0; l < LANES; l++) bus.in_data[l] = '0;
      repeat (2) step();
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_sum", 32'(bus.out_sum), 32'd0);
      check("rst_beats_left", 32'(beats_left), 32'd0);
      rst_n = 1'b1;
      step();

      // Single beat {1,2,3,4,5} -> 15.
      for (int l = 0; l < LANES; l++) pat[l] = WIDTH'(l + 1);
      run_job(1, 1'b0, 0, 1'b0, 1'b0);

      // Three beats of 0x1000 with 2-cycle gaps -> 0xF000.
      for (int l = 0; l < LANES; l++) pat[l] = 16'h1000;
      hs_before = hs_count;
      run_job(3, 1'b0, 2, 1'b0, 1'b0);
      check("three_handshakes", 32'(hs_count - hs_before), 32'd3);

      // Wrap-around: 10 x 0xFFFF -> 0xFFF6.
      for (int l = 0; l < LANES; l++) pat[l] = 16'hFFFF;
      run_job(2, 1'b0, 0, 1'b0, 1'b0);

      // Zero-length job: DONE next cycle with out_sum cleared.
      bus.out_ready = 1'b0;
      do_start(0);
      check("zero_done_valid", 32'(bus.out_valid), 32'd1);
      check("zero_out_sum", 32'(bus.out_sum), 32'd0);
      sb_q.push_back('0);
      wait_done(1'b0);

      // Backpressure with start pulsed during DONE.
      run_job(2, 1'b1, 0, 1'b0, 1'b1);

      // Abort after 2 of 4 beats, with a beat offered in the abort cycle.
      do_start(4);
      for (int b = 0; b < 2; b++) begin
         for (int l = 0; l < LANES; l++) pat[l] = WIDTH'($urandom);
         send_beat(pat);
      end
      bus.in_valid = 1'b1;
      abort        = 1'b1;
      step();
      abort        = 1'b0;
      bus.in_valid = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_beats_left", 32'(beats_left), 32'd0);
      for (int k = 0; k < 3; k++) begin
         check("abort_no_valid", 32'(bus.out_valid), 32'd0);
         step();
      end
      for (int l = 0; l < LANES; l++) pat[l] = 16'd1;
      run_job(1, 1'b0, 0, 1'b0, 1'b0);

      // Reset mid-ACCUM: no result, everything cleared, next job clean.
      do_start(3);
      for (int l = 0; l < LANES; l++) pat[l] = WIDTH'($urandom);
      send_beat(pat);
      rst_n = 1'b0;
      repeat (2) step();
      check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_out_sum", 32'(bus.out_sum), 32'd0);
      check("midrst_beats_left", 32'(beats_left), 32'd0);
      rst_n = 1'b1;
      step();
      for (int l = 0; l < LANES; l++) pat[l] = 16'd1;
      run_job(1, 1'b0, 0, 1'b0, 1'b0);

      // Abort in DONE beats a same-cycle output handshake.
      bus.out_ready = 1'b0;
      do_start(1);
      for (int l = 0; l < LANES; l++) pat[l] = WIDTH'($urandom);
      send_beat(pat);
      step();
      check("abort_done_valid", 32'(bus.out_valid), 32'd1);
      abort         = 1'b1;
      bus.out_ready = 1'b1;
      step();
      abort = 1'b0;
      check("abort_done_dropped", 32'(bus.out_valid), 32'd0);
      check("abort_done_busy", 32'(busy), 32'd0);

      // Randomized jobs with random gaps and random consumer stalls.
      for (int j = 0; j < 8; j++) begin
         run_job($urandom_range(1, 6), 1'b1, -1, 1'b1, 1'b0);
      end

      // Longest job: no counter wrap.
      run_job(255, 1'b1, 0, 1'b0, 1'b0);

      step();
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_csa_accum_seq
